// File: rtl/ps2_mouse_quad.sv
// ps2_mouse_quad: PS/2 mouse packets to Atari ST quadrature; define PS2_MOUSE_TIMEOUT_EN for a frame timeout
module ps2_mouse_quad #(
  parameter int ACC_W   = 10,
  parameter int DIV_W   = 10,
  parameter int TMO_CYC = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mouse_clk,
  input  logic       mouse_data,
  output logic [5:0] mouse_atari,
  output logic       pkt_valid,
  output logic       frame_err
);
  typedef enum logic [1:0] {HDR, DX, DY} state_t;
  localparam logic signed [ACC_W+1:0] PMAX = (ACC_W+2)'(2**(ACC_W-1)-1);
  localparam logic signed [ACC_W+1:0] ONE  = (ACC_W+2)'(1);
  state_t state, state_d;
  logic [2:0] clk_sr;
  logic [1:0] dat_sr;
  logic [3:0] bit_cnt;
  logic [7:0] sr, dx;
  logic [5:0] hdr;
  logic       par, fall, d, stop_smp, byte_ok, byte_bad, tmo_hit, commit, tick;
  logic [1:0] btn, x_cnt, y_cnt;
  logic signed [ACC_W-1:0] acc_x, acc_y;
  logic signed [ACC_W+1:0] dlt_x, dlt_y;
  logic [DIV_W-1:0] div;
  function automatic logic signed [ACC_W-1:0] upd(input logic signed [ACC_W-1:0] a,
                                                  input logic signed [ACC_W+1:0] dl, input logic stp);
    logic signed [ACC_W+1:0] t;
    t = (ACC_W+2)'(a) + dl;
    t = t > PMAX ? PMAX : t < -PMAX ? -PMAX : t;
    if (stp && a != '0) t = a[ACC_W-1] ? t + ONE : t - ONE;
    t = t > PMAX ? PMAX : t < -PMAX ? -PMAX : t;
    return t[ACC_W-1:0];
  endfunction
  function automatic logic [1:0] gstep(input logic [1:0] c, input logic signed [ACC_W-1:0] a);
    return a == '0 ? c : a[ACC_W-1] ? {~c[0], c[1]} : {c[0], ~c[1]};
  endfunction
  assign fall     = clk_sr[2] & ~clk_sr[1];
  assign d        = dat_sr[1];
  assign stop_smp = fall && bit_cnt == 4'd10;
  assign byte_ok  = stop_smp && d && (^{sr, par});
  assign byte_bad = stop_smp && !byte_ok;
  assign tick     = div == '0;
  assign dlt_x    = (commit && !hdr[4]) ? (ACC_W+2)'($signed({hdr[2], dx})) : '0;
  assign dlt_y    = (commit && !hdr[5]) ? -((ACC_W+2)'($signed({hdr[3], sr}))) : '0;
  assign mouse_atari = {btn, y_cnt, x_cnt};
`ifdef PS2_MOUSE_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo;
  assign tmo_hit = bit_cnt != 4'd0 && !fall && tmo == TW'(TMO_CYC - 1);
  always_ff @(posedge clk)
    if (reset) tmo <= '0;
    else tmo <= (bit_cnt == 4'd0 || fall || tmo_hit) ? '0 : tmo + 1'b1;
`else
  assign tmo_hit = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sr  <= 3'b111;
      dat_sr  <= 2'b11;
      bit_cnt <= '0;
      sr      <= '0;
      par     <= 1'b0;
    end else begin
      clk_sr <= {clk_sr[1:0], mouse_clk};
      dat_sr <= {dat_sr[0], mouse_data};
      if (tmo_hit) bit_cnt <= '0;
      else if (fall) begin
        bit_cnt <= bit_cnt == 4'd0 ? {3'b000, ~d} : bit_cnt == 4'd10 ? 4'd0 : bit_cnt + 4'd1;
        if (bit_cnt inside {[4'd1:4'd8]}) sr <= {d, sr[7:1]};
        if (bit_cnt == 4'd9) par <= d;
      end
    end
  end
  always_comb begin
    state_d = state;
    commit  = 1'b0;
    if (byte_bad || tmo_hit) state_d = HDR;
    else if (byte_ok) begin
      state_d = state == HDR ? (sr[3] ? DX : HDR) : state == DX ? DY : HDR;
      commit  = state == DY;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HDR;
      hdr       <= '0;
      dx        <= '0;
      btn       <= '0;
      acc_x     <= '0;
      acc_y     <= '0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      div       <= '0;
      pkt_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_d;
      div       <= div + 1'b1;
      pkt_valid <= commit;
      frame_err <= byte_bad | tmo_hit;
      if (byte_ok && state == HDR && sr[3]) hdr <= {sr[7:4], sr[1:0]};
      if (byte_ok && state == DX) dx <= sr;
      if (commit) btn <= hdr[1:0];
      acc_x <= upd(acc_x, dlt_x, tick);
      acc_y <= upd(acc_y, dlt_y, tick);
      if (tick) begin
        x_cnt <= gstep(x_cnt, acc_x);
        y_cnt <= gstep(y_cnt, acc_y);
      end
    end
  end
endmodule

// File: tb/tb_ps2_mouse_quad.sv
// tb_ps2_mouse_quad: randomized PS/2 packet stimulus against an integer reference model
module tb_ps2_mouse_quad;
  localparam int ACC_W = 9, DIV_W = 6, TMO_CYC = 200, H = 3, MAXV = 2**(ACC_W-1) - 1;
  logic clk = 0, reset = 1, mouse_clk = 1, mouse_data = 1;
  logic [5:0] mouse_atari;
  logic pkt_valid, frame_err;
  ps2_mouse_quad #(.ACC_W(ACC_W), .DIV_W(DIV_W), .TMO_CYC(TMO_CYC)) dut (
    .clk(clk), .reset(reset), .mouse_clk(mouse_clk), .mouse_data(mouse_data),
    .mouse_atari(mouse_atari), .pkt_valid(pkt_valid), .frame_err(frame_err));
  always #5 clk = ~clk;
  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  int edge_cnt = 0, commit_at = -1, div_m = 0, m_ax = 0, m_ay = 0, px = 0, py = 0, m_btn = 0;
  int p_dx = 0, p_dy = 0, p_btn = 0, mfx = 0, mbx = 0, mfy = 0, mby = 0;
  logic [1:0] gt [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  function automatic int sat(input int v);
    return v > MAXV ? MAXV : v < -MAXV ? -MAXV : v;
  endfunction
  function automatic int sgn(input int v);
    return v > 0 ? 1 : v < 0 ? -1 : 0;
  endfunction
  always @(posedge clk) begin
    int sx, sy;
    edge_cnt++;
    if (reset) begin
      div_m = 0; m_ax = 0; m_ay = 0; px = 0; py = 0; m_btn = 0;
    end else begin
      sx = div_m == 0 ? sgn(m_ax) : 0;
      sy = div_m == 0 ? sgn(m_ay) : 0;
      div_m = (div_m + 1) % (1 << DIV_W);
      if (edge_cnt == commit_at) begin
        m_ax = sat(m_ax + p_dx);
        m_ay = sat(m_ay - p_dy);
        m_btn = p_btn;
      end
      m_ax = sat(m_ax - sx);
      m_ay = sat(m_ay - sy);
      px += sx; py += sy;
      mfx += int'(sx == 1); mbx += int'(sx == -1);
      mfy += int'(sy == 1); mby += int'(sy == -1);
    end
  end
  int cyc = 0, phase = 0, exp_pkt = 0, exp_ferr = 0, got_pkt = 0, got_ferr = 0;
  int dfx = 0, dbx = 0, dfy = 0, dby = 0;
  logic [1:0] prev_x = 0, prev_y = 0;
  logic [7:0] hdr_m = 0, dx_m = 0;
  task automatic cyc1();
    @(negedge clk);
    cyc++;
    if (pkt_valid) got_pkt++;
    if (frame_err) got_ferr++;
    if (!reset) begin
      if (mouse_atari[1:0] != prev_x) begin
        if (mouse_atari[1:0] == {prev_x[0], ~prev_x[1]}) dfx++; else dbx++;
      end
      if (mouse_atari[3:2] != prev_y) begin
        if (mouse_atari[3:2] == {prev_y[0], ~prev_y[1]}) dfy++; else dby++;
      end
    end
    prev_x = mouse_atari[1:0];
    prev_y = mouse_atari[3:2];
    if (cyc % 16 == 0 && n_err < 40)
      chk("atari", int'(mouse_atari), int'({m_btn[1:0], gt[py & 3], gt[px & 3]}));
  endtask
  task automatic wait_n(input int n);
    repeat (n) cyc1();
  endtask
  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      exp_ferr++;
      phase = 0;
    end else if (phase == 0) begin
      if (b[3]) begin hdr_m = b; phase = 1; end
    end else if (phase == 1) begin
      dx_m = b; phase = 2;
    end else begin
      p_dx = hdr_m[6] ? 0 : (hdr_m[4] ? int'(dx_m) - 256 : int'(dx_m));
      p_dy = hdr_m[7] ? 0 : (hdr_m[5] ? int'(b) - 256 : int'(b));
      p_btn = int'(hdr_m[1:0]);
      commit_at = edge_cnt + 3;
      exp_pkt++;
      phase = 0;
    end
  endtask
  task automatic send_bits(input logic [7:0] b, input int n, input bit bad);
    logic [10:0] f;
    f = {1'b1, ~(^b) ^ bad, b, 1'b0};
    for (int i = 0; i < n; i++) begin
      mouse_data = f[i];
      wait_n(H);
      mouse_clk = 0;
      if (i == 10) model_byte(b, !bad);
      wait_n(H);
      mouse_clk = 1;
    end
    mouse_data = 1;
    wait_n(4);
  endtask
  task automatic send_byte(input logic [7:0] b, input bit bad = 0);
    send_bits(b, 11, bad);
  endtask
  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0); send_byte(b1); send_byte(b2);
  endtask
  task automatic do_reset();
    reset = 1;
    wait_n(1);
    chk("rst_atari", int'(mouse_atari), 0);
    chk("rst_pulses", int'({pkt_valid, frame_err}), 0);
    wait_n(2);
    reset = 0;
    phase = 0;
    commit_at = -1;
    wait_n(1);
    chk("post_rst_atari", int'(mouse_atari), 0);
    chk("post_rst_pulses", int'({pkt_valid, frame_err}), 0);
  endtask
  task automatic drain();
    int n = 0;
    while ((m_ax != 0 || m_ay != 0) && n < 20000) begin cyc1(); n++; end
    chk("drain_bound", int'(n < 20000), 1);
    wait_n(2 << DIV_W);
  endtask
  task automatic totals(input string tag);
    chk({tag, "_pkt"}, got_pkt, exp_pkt);
    chk({tag, "_ferr"}, got_ferr, exp_ferr);
    chk({tag, "_steps"}, dfx * 1000000 + dbx * 10000 + dfy * 100 + dby, mfx * 1000000 + mbx * 10000 + mfy * 100 + mby);
  endtask
  initial begin
    int s0, s1, s2, s3;
    logic [7:0] b0, b1, b2;
    do_reset();
    s0 = dfx; s1 = dfy + dby;
    send_pkt(8'h09, 8'h05, 8'h00);
    drain();
    chk("r028_fwd", dfx - s0, 5);
    chk("r028_x", int'(mouse_atari[1:0]), 1);
    chk("r028_y", dfy + dby - s1, 0);
    chk("r028_btn", int'(mouse_atari[5:4]), 1);
    totals("r028");
    s0 = dbx; s1 = dfy;
    send_pkt(8'h38, 8'hFB, 8'h02);
    drain();
    chk("r029_xback", dbx - s0, 5);
    chk("r029_yfwd", dfy - s1, 254);
    totals("r029");
    s0 = got_ferr; s1 = got_pkt;
    send_byte(8'h08, 1);
    send_pkt(8'h08, 8'h03, 8'h04);
    drain();
    chk("r030_ferr", got_ferr - s0, 1);
    chk("r030_pkt", got_pkt - s1, 1);
    totals("r030");
    s0 = dfx + dbx; s1 = dfy + dby; s2 = got_pkt;
    send_pkt(8'h48, 8'h10, 8'h00);
    drain();
    chk("r032_pkt", got_pkt - s2, 1);
    chk("r032_xy", dfx + dbx - s0 + dfy + dby - s1, 0);
    chk("r032_btn", int'(mouse_atari[5:4]), 0);
    s0 = dfx; s1 = mfx;
    repeat (4) send_pkt(8'h08, 8'h7F, 8'h00);
    chk("r031_clamp", int'(m_ax == MAXV), 1);
    drain();
    chk("r031_fwd", dfx - s0, mfx - s1);
    totals("r031");
    s0 = got_pkt; s1 = got_ferr;
    send_byte(8'h09);
    send_bits(8'h33, 5, 0);
    do_reset();
    chk("rst_mid_pkt", got_pkt - s0, 0);
    chk("rst_mid_ferr", got_ferr - s1, 0);
    send_byte(8'h00);
    send_pkt(8'h09, 8'h02, 8'h00);
    drain();
    chk("rst_then_pkt", got_pkt - s0, 1);
    totals("rst");
    for (int k = 0; k < 12; k++) begin
      b0 = {($urandom_range(7) == 0) ? 1'b1 : 1'b0, ($urandom_range(7) == 0) ? 1'b1 : 1'b0,
            2'($urandom), 1'b1, 1'($urandom), 2'($urandom)};
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      s3 = $urandom_range(5);
      if ($urandom_range(7) == 0) send_byte(8'($urandom) & 8'hF7);
      send_byte(b0, s3 == 0);
      send_byte(b1, s3 == 1);
      send_byte(b2, s3 == 2);
      wait_n($urandom_range(40));
    end
    drain();
    totals("rand");
`ifdef PS2_MOUSE_TIMEOUT_EN
    s0 = got_ferr; s1 = got_pkt;
    send_bits(8'h09, 4, 0);
    wait_n(TMO_CYC + 10);
    exp_ferr++;
    phase = 0;
    chk("tmo_ferr", got_ferr - s0, 1);
    send_pkt(8'h09, 8'h01, 8'h00);
    drain();
    chk("tmo_pkt", got_pkt - s1, 1);
    totals("tmo");
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
